// File: rtl/my_alu_pkg.sv
// Shared opcode and FSM encodings for the
// chunk-serial bitwise logic unit.
package my_alu_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   function automatic int chunk_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/my_logic_slice.sv
// One CHUNK-wide slice of the bitwise operation;
// purely combinational, shared across all chunks.
module my_logic_slice
   import my_alu_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic [1:0]       op,
   output logic [CHUNK-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/my_logic_unit_seq.sv
// Multi-cycle bitwise logic unit: computes op(a, b)
// one CHUNK per cycle, LSB chunk first.
module my_logic_unit_seq
   import my_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = chunk_idx_w(N);

   localparam logic [KW-1:0] K_ONE  = KW'(1);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;

   logic [CHUNK-1:0] w_sa;
   logic [CHUNK-1:0] w_sb;
   logic [CHUNK-1:0] w_y;
   logic [WIDTH-1:0] w_result_nxt;
   logic             w_last;

   assign w_last = (r_k == K_LAST);

   // Select the operand chunk addressed by k.
   always_comb begin
      w_sa = '0;
      w_sb = '0;
      for (int i = 0; i < N; i++) begin
         if (r_k == KW'(i)) begin
            w_sa = r_a[i*CHUNK +: CHUNK];
            w_sb = r_b[i*CHUNK +: CHUNK];
         end
      end
   end

   my_logic_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a  (w_sa),
      .b  (w_sb),
      .op (r_op),
      .y  (w_y)
   );

   always_comb begin
      w_result_nxt = r_result;
      for (int i = 0; i < N; i++) begin
         if (r_k == KW'(i)) begin
            w_result_nxt[i*CHUNK +: CHUNK] = w_y;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_k      <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= OP_AND;
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && start) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= op;
            r_k      <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
         end
         if (r_state == ST_RUN) begin
            r_result <= w_result_nxt;
            r_zero   <= (w_result_nxt == '0);
            r_k      <= w_last ? '0 : r_k + K_ONE;
         end
      end
   end

   assign busy   = (r_state != ST_IDLE);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;
   assign zero   = r_zero;

endmodule

// File: tb/tb_my_logic_unit_seq.sv
// Directed table-driven bench for my_logic_unit_seq,
// plus multi-cycle corner sequences.
module tb_my_logic_unit_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;

   logic        start2;
   logic [1:0]  op2;
   logic [15:0] a2;
   logic [15:0] b2;
   logic        busy2;
   logic        done2;
   logic [15:0] result2;
   logic        zero2;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
   } vec_t;

   vec_t vecs[6];

   my_logic_unit_seq #(
      .WIDTH (32),
      .CHUNK (8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero)
   );

   my_logic_unit_seq #(
      .WIDTH (16),
      .CHUNK (16)
   ) dut2 (
      .clk    (clk),
      .reset  (reset),
      .start  (start2),
      .op     (op2),
      .a      (a2),
      .b      (b2),
      .busy   (busy2),
      .done   (done2),
      .result (result2),
      .zero   (zero2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [63:0] m;
      op    = v.op;
      a     = v.a;
      b     = v.b;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("accept_busy", 64'(busy), 64'd1);
      chk("accept_done", 64'(done), 64'd0);
      chk("accept_clr", 64'(result), 64'd0);
      for (int j = 1; j <= 4; j++) begin
         tick();
         m = (64'd1 << (j * 8)) - 64'd1;
         chk("run_partial", 64'(result), 64'(v.res) & m);
         chk("run_busy", 64'(busy), 64'd1);
         chk("run_done", 64'(done), (j == 4) ? 64'd1 : 64'd0);
      end
      chk("done_zero", 64'(zero), 64'(v.z));
      tick();
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_hold", 64'(result), 64'(v.res));
      chk("idle_zero", 64'(zero), 64'(v.z));
   endtask

   initial begin
      int ndone;
      n_cmp  = 0;
      n_bad  = 0;
      reset  = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      start2 = 1'b0;
      op2    = 2'b00;
      a2     = '0;
      b2     = '0;

      vecs[0] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vecs[1] = '{2'b00, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1};
      vecs[2] = '{2'b10, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1'b0};
      vecs[3] = '{2'b01, 32'h0000_00A5, 32'h5A00_0000, 32'h5A00_00A5, 1'b0};
      vecs[4] = '{2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 1'b0};
      vecs[5] = '{2'b11, 32'hFFFF_0000, 32'h0000_FF00, 32'h0000_00FF, 1'b0};

      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_zero", 64'(zero), 64'd1);
      chk("rst2_result", 64'(result2), 64'd0);
      chk("rst2_zero", 64'(zero2), 64'd1);
      reset = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // start re-pulsed and a changed mid-operation
      op    = 2'b01;
      a     = 32'h0000_00A5;
      b     = 32'h5A00_0000;
      start = 1'b1;
      tick();
      a     = 32'h0;
      ndone = 0;
      for (int j = 1; j <= 8; j++) begin
         if (j == 3) start = 1'b0;
         tick();
         if (done) ndone++;
         if (j == 4) chk("inflight_res", 64'(result), 64'h5A00_00A5);
      end
      chk("inflight_ndone", 64'(ndone), 64'd1);
      chk("inflight_idle", 64'(busy), 64'd0);

      // reset aborts an operation after E2
      op    = 2'b11;
      a     = '0;
      b     = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      start = 1'b1;
      tick();
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_zero", 64'(zero), 64'd1);
      reset = 1'b0;
      run_vec(vecs[2]);

      // start held: done every 6 cycles
      op    = 2'b11;
      a     = '0;
      b     = '0;
      start = 1'b1;
      tick();
      for (int j = 1; j <= 11; j++) begin
         tick();
         chk("held_done", 64'(done),
             (j == 4 || j == 10) ? 64'd1 : 64'd0);
         if (j == 4 || j == 10)
            chk("held_res", 64'(result), 64'hFFFF_FFFF);
      end
      start = 1'b0;
      tick();
      chk("held_stop", 64'(busy), 64'd0);

      // single-chunk instance
      op2    = 2'b11;
      a2     = 16'h00FF;
      b2     = 16'h0F00;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      chk("n1_busy", 64'(busy2), 64'd1);
      chk("n1_early", 64'(done2), 64'd0);
      tick();
      chk("n1_done", 64'(done2), 64'd1);
      chk("n1_result", 64'(result2), 64'hF000);
      chk("n1_zero", 64'(zero2), 64'd0);
      tick();
      chk("n1_idle", 64'(busy2), 64'd0);
      chk("n1_hold", 64'(result2), 64'hF000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
